// File: rtl/vga_pixel_engine.sv
// vga_pixel_engine: pixel sequencer for a 160x120, 12-bit colour framebuffer.
// Emits one pixel per enabled cycle, either a full-screen background clear or
// one period of a sine wave. Optional macro VGA_SIN_AXIS_EN appends a
// horizontal axis line (Y = 60) to the sine job.
module vga_pixel_engine #(
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] FG_COLOR   = 12'hFFF
`ifdef VGA_SIN_AXIS_EN
  ,
  parameter logic [11:0] AXIS_COLOR = 12'h0F0
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  output logic [7:0]  CounterX,
  output logic [7:0]  CounterY,
  output logic [11:0] color,
  output logic        plot,
  output logic        finished
);

  localparam logic [7:0] H_LAST = 8'd159;
  localparam logic [7:0] V_LAST = 8'd119;
  localparam logic [7:0] Y_MID  = 8'd60;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [11:0] color_q, color_d;
  logic        plot_q, plot_d;
  logic        finished_q, finished_d;
  logic        mode_q, mode_d;
`ifdef VGA_SIN_AXIS_EN
  logic        axis_q, axis_d;
`endif

  logic [7:0]  x_nxt;
  logic        last_pix;

  // First quadrant of round(50 * sin(2*pi*i/160)), i = 0..40.
  function automatic logic [5:0] sine_rom(input logic [7:0] idx);
    case (idx)
      8'd0:  sine_rom = 6'd0;   8'd1:  sine_rom = 6'd2;   8'd2:  sine_rom = 6'd4;
      8'd3:  sine_rom = 6'd6;   8'd4:  sine_rom = 6'd8;   8'd5:  sine_rom = 6'd10;
      8'd6:  sine_rom = 6'd12;  8'd7:  sine_rom = 6'd14;  8'd8:  sine_rom = 6'd15;
      8'd9:  sine_rom = 6'd17;  8'd10: sine_rom = 6'd19;  8'd11: sine_rom = 6'd21;
      8'd12: sine_rom = 6'd23;  8'd13: sine_rom = 6'd24;  8'd14: sine_rom = 6'd26;
      8'd15: sine_rom = 6'd28;  8'd16: sine_rom = 6'd29;  8'd17: sine_rom = 6'd31;
      8'd18: sine_rom = 6'd32;  8'd19: sine_rom = 6'd34;  8'd20: sine_rom = 6'd35;
      8'd21: sine_rom = 6'd37;  8'd22: sine_rom = 6'd38;  8'd23: sine_rom = 6'd39;
      8'd24: sine_rom = 6'd40;  8'd25: sine_rom = 6'd42;  8'd26: sine_rom = 6'd43;
      8'd27: sine_rom = 6'd44;  8'd28: sine_rom = 6'd45;  8'd29: sine_rom = 6'd45;
      8'd30: sine_rom = 6'd46;  8'd31: sine_rom = 6'd47;  8'd32: sine_rom = 6'd48;
      8'd33: sine_rom = 6'd48;  8'd34: sine_rom = 6'd49;  8'd35: sine_rom = 6'd49;
      8'd36: sine_rom = 6'd49;  8'd37: sine_rom = 6'd50;  8'd38: sine_rom = 6'd50;
      8'd39: sine_rom = 6'd50;  8'd40: sine_rom = 6'd50;
      default: sine_rom = 6'd0;
    endcase
  endfunction

  // Fold X into the first quadrant, look up, and map to screen Y (down is +).
  function automatic logic [7:0] sine_y(input logic [7:0] x);
    logic [7:0] idx;
    logic       neg;
    logic [6:0] s;
    if (x <= 8'd40) begin
      idx = x;            neg = 1'b0;
    end else if (x <= 8'd80) begin
      idx = 8'd80 - x;    neg = 1'b0;
    end else if (x <= 8'd120) begin
      idx = x - 8'd80;    neg = 1'b1;
    end else begin
      idx = 8'd160 - x;   neg = 1'b1;
    end
    s = {1'b0, sine_rom(idx)};
    if (neg) s = -s;
    sine_y = Y_MID - {s[6], s};
  endfunction

  assign x_nxt = (x_q == H_LAST) ? 8'd0 : x_q + 8'd1;

`ifdef VGA_SIN_AXIS_EN
  assign last_pix = mode_q ? (axis_q && x_q == H_LAST) : (x_q == H_LAST && y_q == V_LAST);
`else
  assign last_pix = mode_q ? (x_q == H_LAST) : (x_q == H_LAST && y_q == V_LAST);
`endif

  // Next-state and next-pixel generation.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    plot_d     = plot_q;
    finished_d = finished_q;
    mode_d     = mode_q;
`ifdef VGA_SIN_AXIS_EN
    axis_d     = axis_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StRun;
          mode_d  = mode;
          plot_d  = 1'b1;
          x_d     = 8'd0;
`ifdef VGA_SIN_AXIS_EN
          axis_d  = 1'b0;
`endif
          if (mode) begin
            y_d     = sine_y(8'd0);
            color_d = FG_COLOR;
          end else begin
            y_d     = 8'd0;
            color_d = BG_COLOR;
          end
        end
      end
      StRun: begin
        if (enable) begin
          if (last_pix) begin
            state_d    = StDone;
            plot_d     = 1'b0;
            finished_d = 1'b1;
          end else begin
            x_d = x_nxt;
            if (mode_q) begin
`ifdef VGA_SIN_AXIS_EN
              // Curve wraps into the axis pass once X passes 159.
              if (axis_q || x_q == H_LAST) begin
                axis_d  = 1'b1;
                y_d     = Y_MID;
                color_d = AXIS_COLOR;
              end else begin
                y_d     = sine_y(x_nxt);
                color_d = FG_COLOR;
              end
`else
              y_d     = sine_y(x_nxt);
              color_d = FG_COLOR;
`endif
            end else begin
              if (x_q == H_LAST) y_d = y_q + 8'd1;
              color_d = BG_COLOR;
            end
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      color_q    <= 12'h000;
      plot_q     <= 1'b0;
      finished_q <= 1'b0;
      mode_q     <= 1'b0;
`ifdef VGA_SIN_AXIS_EN
      axis_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      plot_q     <= plot_d;
      finished_q <= finished_d;
      mode_q     <= mode_d;
`ifdef VGA_SIN_AXIS_EN
      axis_q     <= axis_d;
`endif
    end
  end

  assign CounterX = x_q;
  assign CounterY = y_q;
  assign color    = color_q;
  assign plot     = plot_q;
  assign finished = finished_q;

endmodule

// File: tb/tb_vga_pixel_engine.sv
// Self-checking bench for vga_pixel_engine: directed clear/sine jobs, a sine
// Y-value table, enable/mode toggling, and mid-job reset abort.
module tb_vga_pixel_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  cx, cy;
  logic [11:0] color;
  logic        plot, finished;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
  } sine_vec_t;

  sine_vec_t vecs[12];
  int sy[160];
  int sc[160];

  vga_pixel_engine dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .CounterX (cx),
    .CounterY (cy),
    .color    (color),
    .plot     (plot),
    .finished (finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step(1'b1);
    reset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"}, 32'(cx), 0);
    check({tag, "_y"}, 32'(cy), 0);
    check({tag, "_color"}, 32'(color), 0);
    check({tag, "_plot"}, 32'(plot), 0);
    check({tag, "_finished"}, 32'(finished), 0);
  endtask

  initial begin
    int mism;
    int ex, ey;

    vecs[0]  = '{0, 60};   vecs[1]  = '{10, 41};  vecs[2]  = '{20, 25};
    vecs[3]  = '{40, 10};  vecs[4]  = '{80, 60};  vecs[5]  = '{120, 110};
    vecs[6]  = '{140, 95}; vecs[7]  = '{30, 14};  vecs[8]  = '{60, 25};
    vecs[9]  = '{100, 95}; vecs[10] = '{1, 58};   vecs[11] = '{159, 62};

    // Reset held with enable high.
    reset = 1'b0; mode = 1'b0;
    repeat (3) step(1'b1);
    check_zero("reset");

    // Idle after release with enable low.
    reset = 1'b1;
    mism = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (cx !== 0 || cy !== 0 || color !== 0 || plot !== 0 || finished !== 0) mism++;
    end
    check("idle_hold", mism, 0);

    // Clear job, enable continuous.
    mode = 1'b0;
    mism = 0;
    for (int c = 1; c <= 19200; c++) begin
      step(1'b1);
      ex = (c - 1) % 160;
      ey = (c - 1) / 160;
      if (cx !== 8'(ex) || cy !== 8'(ey) || color !== 12'h000 || plot !== 1'b1 ||
          finished !== 1'b0) mism++;
      if (c == 1) begin
        check("clr_c1_x", 32'(cx), 0);
        check("clr_c1_y", 32'(cy), 0);
        check("clr_c1_plot", 32'(plot), 1);
      end
      if (c == 161) begin
        check("clr_c161_x", 32'(cx), 0);
        check("clr_c161_y", 32'(cy), 1);
      end
      if (c == 19200) begin
        check("clr_last_x", 32'(cx), 159);
        check("clr_last_y", 32'(cy), 119);
      end
    end
    check("clr_raster", mism, 0);
    step(1'b1);
    check("clr_fin", 32'(finished), 1);
    check("clr_fin_plot", 32'(plot), 0);
    check("clr_fin_x", 32'(cx), 159);
    check("clr_fin_y", 32'(cy), 119);
    repeat (3) step(1'b1);
    check("clr_fin_held", 32'(finished), 1);

    // Sine job, enable continuous.
    pulse_reset();
    mode = 1'b1;
    mism = 0;
    for (int i = 0; i < 160; i++) begin
      step(1'b1);
      sy[i] = int'(cy);
      sc[i] = int'(color);
      if (cx !== 8'(i) || plot !== 1'b1 || finished !== 1'b0 || color !== 12'hFFF) mism++;
    end
    check("sine_seq", mism, 0);
    for (int k = 0; k < 12; k++)
      check($sformatf("sine_y_x%0d", vecs[k].x), sy[vecs[k].x], vecs[k].y);
`ifdef VGA_SIN_AXIS_EN
    mism = 0;
    for (int i = 0; i < 160; i++) begin
      step(1'b1);
      if (cx !== 8'(i) || cy !== 8'd60 || color !== 12'h0F0 || plot !== 1'b1 ||
          finished !== 1'b0) mism++;
      if (i == 0) check("axis_first_color", 32'(color), 32'h0F0);
      if (i == 159) check("axis_last_x", 32'(cx), 159);
    end
    check("axis_seq", mism, 0);
`endif
    step(1'b1);
    check("sine_fin", 32'(finished), 1);
    check("sine_fin_plot", 32'(plot), 0);

    // Sine job with enable toggling and mode wiggling after start.
    pulse_reset();
    mode = 1'b1;
    mism = 0;
    for (int i = 0; i < 160; i++) begin
      step(1'b1);
      mode = ~mode;
      if (cx !== 8'(i) || int'(cy) != sy[i] || int'(color) != sc[i] || plot !== 1'b1) mism++;
      step(1'b0);
      mode = ~mode;
      if (cx !== 8'(i) || int'(cy) != sy[i] || int'(color) != sc[i] || plot !== 1'b1) mism++;
    end
`ifdef VGA_SIN_AXIS_EN
    for (int i = 0; i < 160; i++) begin
      step(1'b1);
      if (cx !== 8'(i) || cy !== 8'd60 || color !== 12'h0F0) mism++;
      step(1'b0);
      if (cx !== 8'(i) || cy !== 8'd60 || color !== 12'h0F0) mism++;
    end
`endif
    check("toggle_seq", mism, 0);
    check("toggle_not_fin", 32'(finished), 0);
    step(1'b1);
    check("toggle_fin", 32'(finished), 1);

    // Abort a clear job at X = 37, then start a fresh sine job.
    pulse_reset();
    mode = 1'b0;
    repeat (38) step(1'b1);
    check("abort_x37", 32'(cx), 37);
    reset = 1'b0;
    step(1'b1);
    check_zero("abort");
    reset = 1'b1;
    mode = 1'b1;
    step(1'b1);
    check("restart_x", 32'(cx), 0);
    check("restart_y", 32'(cy), 60);
    check("restart_color", 32'(color), 32'hFFF);
    check("restart_plot", 32'(plot), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
